// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccff_loader_pkg
// Description : Shared definitions for the ccff bitstream loader.
//               - state_t     : loader FSM states
//               - CRC16_POLY  : CRC-16-CCITT polynomial (0x1021)
//               - CRC16_INIT  : CRC seed (0xFFFF)
//               - crc16_step  : one bit-serial CRC update
// Revision    : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // MSB-first serial CRC: feedback is the outgoing MSB xor the new bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage : ccff_loader_pkg
`default_nettype wire

// File: rtl/ccff_crc16_serial.sv
`default_nettype none
// ============================================================================
// Module      : ccff_crc16_serial
// Description : Bit-serial CRC-16-CCITT accumulator.
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset (loads CRC16_INIT)
//   en      in   fold bit_in into the CRC this cycle
//   clr     in   reload CRC16_INIT (has priority over en)
//   bit_in  in   serial data bit
//   crc_out out  current CRC value
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC16_INIT;
        end else if (clr) begin
            r_crc <= CRC16_INIT;
        end else if (en) begin
            r_crc <= crc16_step(r_crc, bit_in);
        end
    end

    assign crc_out = r_crc;

endmodule : ccff_crc16_serial
`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_bitstream_loader
// Description : Host-side writer for the configuration flip-flop chain.
//               Serializes host words MSB-first into ccff_head, then rotates
//               the chain once (tail looped back to head) while checking a
//               CRC of the returned stream against the CRC of the loaded one.
//               Pads stay isolated until the chain is loaded and verified.
//   prog_clk      in   programming clock
//   pReset_N      in   asynchronous active-low reset
//   start         in   begin programming (honoured in IDLE / DONE only)
//   word_valid    in   host word available
//   word_data     in   bitstream word (MSB shifted first)
//   word_ready    out  word accepted this cycle
//   ccff_head     out  serial data into the chain
//   ccff_shift_en out  chain advances on this edge
//   ccff_tail     in   serial data out of the chain
//   IO_ISOL_N     out  0 = pads isolated
//   busy          out  LOAD, SHIFT or CHECK in progress
//   done          out  programming finished (level)
//   crc_err       out  verify mismatch (valid while done=1)
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_N,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int               c_WBIT_W   = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WORD_W-1:0]     r_sreg;
    logic [c_WBIT_W-1:0]   r_wbit;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_crc_err;

    logic                  w_last_bit;
    logic                  w_crc_clr;
    logic                  w_load_en;
    logic                  w_chk_en;
    logic [15:0]           w_crc_load;
    logic [15:0]           w_crc_chk;

    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk or negedge pReset_N) begin
        if (!pReset_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and chain-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        word_ready    = 1'b0;
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        w_crc_clr     = 1'b0;
        w_load_en     = 1'b0;
        w_chk_en      = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_crc_clr   = 1'b1;
                end
            end
            LOAD: begin
                // Chain holds while the host stalls.
                word_ready = 1'b1;
                if (word_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = r_sreg[WORD_W-1];
                w_load_en     = 1'b1;
                // Chain end wins over word end: leftover bits of the final
                // word are simply dropped.
                if (w_last_bit) begin
                    w_state_nxt = CHECK;
                end else if (r_wbit == c_WBIT_W'(1)) begin
                    w_state_nxt = LOAD;
                end
            end
            CHECK: begin
                // One full rotation restores the loaded contents.
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                w_chk_en      = 1'b1;
                if (w_last_bit) begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: word shifter, bit counters, verify result
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk or negedge pReset_N) begin
        if (!pReset_N) begin
            r_sreg    <= '0;
            r_wbit    <= '0;
            r_bit_cnt <= '0;
            r_crc_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_bit_cnt <= '0;
                        r_crc_err <= 1'b0;
                    end
                end
                LOAD: begin
                    if (word_valid) begin
                        r_sreg <= word_data;
                        r_wbit <= c_WBIT_W'(WORD_W);
                    end
                end
                SHIFT: begin
                    r_sreg    <= r_sreg << 1;
                    r_wbit    <= r_wbit - c_WBIT_W'(1);
                    r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
                end
                CHECK: begin
                    r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
                    // The checker register only absorbs the last tail bit on
                    // this same edge, so fold it in here for the comparison.
                    if (w_last_bit) begin
                        r_crc_err <= (crc16_step(w_crc_chk, ccff_tail) != w_crc_load);
                    end
                end
                default: begin
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // CRC of the bits sent and of the bits returned by the rotation
    // ------------------------------------------------------------------
    ccff_crc16_serial u_crc_load (
        .clk     (prog_clk),
        .rst_n   (pReset_N),
        .en      (w_load_en),
        .clr     (w_crc_clr),
        .bit_in  (ccff_head),
        .crc_out (w_crc_load)
    );

    ccff_crc16_serial u_crc_chk (
        .clk     (prog_clk),
        .rst_n   (pReset_N),
        .en      (w_chk_en),
        .clr     (w_crc_clr),
        .bit_in  (ccff_tail),
        .crc_out (w_crc_chk)
    );

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign busy      = (r_state == LOAD) || (r_state == SHIFT) || (r_state == CHECK);
    assign done      = (r_state == DONE);
    assign crc_err   = r_crc_err;
    assign IO_ISOL_N = done && !r_crc_err;

endmodule : ccff_bitstream_loader
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_bitstream_loader
// Description : Self-checking bench. Two loaders (8-bit and 10-bit chains,
//               4-bit words) each drive a behavioural chain model; the
//               expected serial stream, final chain contents, handshake
//               count and latency are derived from the word list directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_bitstream_loader;

    logic       prog_clk = 1'b0;
    logic       pReset_N;
    logic       start;
    logic       word_valid;
    logic [3:0] word_data;
    bit         sel;          // 0 = 8-bit chain loader, 1 = 10-bit chain loader

    int         cur_len;
    int         sh_cnt;
    bit         fault_en;
    logic [3:0] wq[$];

    int n_checks = 0;
    int n_errors = 0;

    // results of the last programming run
    bit          r_timeout;
    int          r_edges, r_hs, r_viol, r_isol_viol;
    logic [15:0] r_sent, r_rcvd;
    bit          r_busy_after, r_done_after, r_isol_after;

    always #5 prog_clk = ~prog_clk;

    // ------------------------------------------------------------------
    // DUTs and chain models
    // ------------------------------------------------------------------
    logic start8, valid8, ready8, head8, sh8, tail8, isol8, busy8, done8, err8;
    logic start10, valid10, ready10, head10, sh10, tail10, isol10, busy10, done10, err10;
    logic [7:0] chain8  = '0;
    logic [9:0] chain10 = '0;

    assign start8  = sel ? 1'b0 : start;
    assign valid8  = sel ? 1'b0 : word_valid;
    assign start10 = sel ? start : 1'b0;
    assign valid10 = sel ? word_valid : 1'b0;

    // the fault corrupts the 4th bit coming out of the tail during rotation
    assign tail8  = chain8[7]  ^ (fault_en && !sel && sh_cnt == 8 + 3);
    assign tail10 = chain10[9] ^ (fault_en &&  sel && sh_cnt == 10 + 3);

    always @(posedge prog_clk) begin
        if (sh8)  chain8  <= {chain8[6:0], head8};
        if (sh10) chain10 <= {chain10[8:0], head10};
    end

    ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(4)) u_dut8 (
        .prog_clk(prog_clk), .pReset_N(pReset_N), .start(start8),
        .word_valid(valid8), .word_data(word_data), .word_ready(ready8),
        .ccff_head(head8), .ccff_shift_en(sh8), .ccff_tail(tail8),
        .IO_ISOL_N(isol8), .busy(busy8), .done(done8), .crc_err(err8)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(10), .WORD_W(4)) u_dut10 (
        .prog_clk(prog_clk), .pReset_N(pReset_N), .start(start10),
        .word_valid(valid10), .word_data(word_data), .word_ready(ready10),
        .ccff_head(head10), .ccff_shift_en(sh10), .ccff_tail(tail10),
        .IO_ISOL_N(isol10), .busy(busy10), .done(done10), .crc_err(err10)
    );

    logic a_ready, a_head, a_sh, a_isol, a_busy, a_done, a_err;
    assign a_ready = sel ? ready10 : ready8;
    assign a_head  = sel ? head10  : head8;
    assign a_sh    = sel ? sh10    : sh8;
    assign a_isol  = sel ? isol10  : isol8;
    assign a_busy  = sel ? busy10  : busy8;
    assign a_done  = sel ? done10  : done8;
    assign a_err   = sel ? err10   : err8;

    // ------------------------------------------------------------------
    // Reference model: bit i of the result is the i-th bit sent
    // ------------------------------------------------------------------
    function automatic logic [15:0] exp_bits();
        logic [15:0] b;
        logic [3:0]  w;
        int          k;
        b = '0;
        k = 0;
        foreach (wq[j]) begin
            w = wq[j];
            for (int t = 3; t >= 0; t--) begin
                if (k < cur_len) b[k] = w[t];
                k++;
            end
        end
        return b;
    endfunction

    // after a full rotation the first bit sent sits next to the tail
    function automatic logic [15:0] exp_chain();
        logic [15:0] b, c;
        b = exp_bits();
        c = '0;
        for (int i = 0; i < cur_len; i++) c[cur_len-1-i] = b[i];
        return c;
    endfunction

    function automatic logic [15:0] cur_chain();
        return sel ? {6'b0, chain10} : {8'b0, chain8};
    endfunction

    function automatic int n_words();
        return (cur_len + 3) / 4;
    endfunction

    function automatic logic [15:0] bit_mask();
        return 16'((32'd1 << cur_len) - 1);
    endfunction

    task automatic fill_random();
        wq.delete();
        for (int i = 0; i < n_words(); i++) wq.push_back(4'($urandom_range(0, 15)));
    endtask

    // ------------------------------------------------------------------
    // Driver: one programming pass, results left in r_* variables
    // ------------------------------------------------------------------
    task automatic program_run(input int stall, input bit fault, input bit poke);
        int idx, nw, stall_left;
        bit fire, sh;
        nw = wq.size();
        idx = 0; stall_left = 0;
        r_sent = '0; r_rcvd = '0; r_viol = 0; r_isol_viol = 0; r_timeout = 1;
        @(negedge prog_clk);
        sh_cnt = 0; fault_en = fault; start = 1'b1; word_valid = 1'b0;
        @(negedge prog_clk);
        start = 1'b0;
        r_edges = 1;
        r_busy_after = a_busy; r_done_after = a_done; r_isol_after = a_isol;
        while (r_edges < 200) begin
            start = poke && (sh_cnt == 3 || sh_cnt == cur_len + 2);
            if (idx < nw && stall_left == 0) begin
                word_valid = 1'b1; word_data = wq[idx];
            end else begin
                word_valid = 1'b0; word_data = 4'($urandom_range(0, 15));
            end
            #1;
            if (a_done) begin
                r_timeout = 0;
                break;
            end
            fire = a_ready && word_valid;
            sh   = a_sh;
            if (a_ready && a_sh) r_viol++;
            if (a_isol) r_isol_viol++;
            if (sh) begin
                if (sh_cnt < cur_len) r_sent[sh_cnt] = a_head;
                else if (sh_cnt < 2 * cur_len) r_rcvd[sh_cnt - cur_len] = a_head;
            end
            if (a_ready && stall_left > 0) stall_left--;
            @(negedge prog_clk);
            r_edges++;
            if (fire) begin
                idx++;
                stall_left = stall;
            end
            if (sh) sh_cnt++;
        end
        r_hs = idx;
        start = 1'b0; word_valid = 1'b0; fault_en = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        pReset_N = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0;
        sh_cnt = 0; fault_en = 1'b0;
        repeat (3) @(negedge prog_clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            n_checks++;
            if ({a_ready, a_head, a_sh, a_isol, a_busy, a_done, a_err} !== 7'b0) begin
                n_errors++;
                $display("FAIL reset_state dut%0d got %b expected 0000000", s,
                         {a_ready, a_head, a_sh, a_isol, a_busy, a_done, a_err});
            end
        end
        @(negedge prog_clk);
        pReset_N = 1'b1;
        repeat (2) @(negedge prog_clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            n_checks++;
            if ({a_ready, a_sh, a_isol, a_busy, a_done, a_err} !== 6'b0) begin
                n_errors++;
                $display("FAIL idle_after_release dut%0d got %b expected 000000", s,
                         {a_ready, a_sh, a_isol, a_busy, a_done, a_err});
            end
        end
    endtask

    task automatic test_basic8();
        sel = 1'b0; cur_len = 8;
        wq.delete(); wq.push_back(4'hA); wq.push_back(4'h5);
        program_run(0, 1'b0, 1'b0);
        n_checks++;
        if (r_timeout || r_sent[7:0] !== 8'b1010_0101) begin
            n_errors++;
            $display("FAIL basic8_head_seq got %b (timeout %0d) expected 10100101 (first bit rightmost)", r_sent[7:0], r_timeout);
        end
        n_checks++;
        if (sh_cnt != 16) begin
            n_errors++; $display("FAIL basic8_shift_cycles got %0d expected 16", sh_cnt);
        end
        n_checks++;
        if ({a_done, a_err, a_isol, a_busy} !== 4'b1010) begin
            n_errors++; $display("FAIL basic8_status got %b expected 1010", {a_done, a_err, a_isol, a_busy});
        end
        n_checks++;
        if (chain8 !== 8'hA5) begin
            n_errors++; $display("FAIL basic8_chain got %h expected a5", chain8);
        end
        n_checks++;
        if (r_edges != 2 * 8 + 2 + 1) begin
            n_errors++; $display("FAIL basic8_latency got %0d expected %0d", r_edges, 2 * 8 + 2 + 1);
        end
        n_checks++;
        if (r_rcvd[7:0] !== 8'b1010_0101 || r_isol_viol != 0) begin
            n_errors++; $display("FAIL basic8_rotation got %b isol_early %0d expected 10100101 0", r_rcvd[7:0], r_isol_viol);
        end
    endtask

    task automatic test_partial10(input int stall);
        sel = 1'b1; cur_len = 10;
        wq.delete(); wq.push_back(4'hF); wq.push_back(4'h0); wq.push_back(4'hC);
        program_run(stall, 1'b0, 1'b0);
        n_checks++;
        if (r_timeout || r_hs != 3) begin
            n_errors++; $display("FAIL partial10_handshakes stall%0d got %0d (timeout %0d) expected 3", stall, r_hs, r_timeout);
        end
        n_checks++;
        if (r_sent[9:0] !== exp_bits()) begin
            n_errors++; $display("FAIL partial10_head_seq stall%0d got %b expected %b", stall, r_sent[9:0], exp_bits());
        end
        n_checks++;
        if (chain10 !== 10'b11_1100_0011 || a_err !== 1'b0 || a_isol !== 1'b1) begin
            n_errors++; $display("FAIL partial10_result stall%0d chain %b err %b isol %b expected 1111000011 0 1", stall, chain10, a_err, a_isol);
        end
        n_checks++;
        if (sh_cnt != 20 || r_viol != 0) begin
            n_errors++; $display("FAIL partial10_shift stall%0d cycles %0d load_shift %0d expected 20 0", stall, sh_cnt, r_viol);
        end
        n_checks++;
        if (r_edges != 2 * 10 + 3 + 1 + stall * 2) begin
            n_errors++; $display("FAIL partial10_latency stall%0d got %0d expected %0d", stall, r_edges, 2 * 10 + 3 + 1 + stall * 2);
        end
    endtask

    task automatic test_fault();
        logic [15:0] eb;
        sel = 1'b0; cur_len = 8;
        fill_random();
        eb = exp_bits();
        program_run(0, 1'b1, 1'b0);
        n_checks++;
        if (r_timeout || {a_done, a_err, a_isol} !== 3'b110) begin
            n_errors++; $display("FAIL fault_status got done %b err %b isol %b (timeout %0d) expected 1 1 0", a_done, a_err, a_isol, r_timeout);
        end
        n_checks++;
        if (r_rcvd[7:0] !== (eb[7:0] ^ 8'h08) || r_isol_viol != 0) begin
            n_errors++; $display("FAIL fault_rotation got %b isol_early %0d expected %b 0", r_rcvd[7:0], r_isol_viol, eb[7:0] ^ 8'h08);
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b1; cur_len = 10;
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; word_valid = 1'b1; word_data = 4'h9;
        repeat (4) @(negedge prog_clk);
        word_valid = 1'b0;
        #1;
        n_checks++;
        if (a_sh !== 1'b1 || a_busy !== 1'b1) begin
            n_errors++; $display("FAIL reset_mid_precondition shift_en %b busy %b expected 1 1", a_sh, a_busy);
        end
        #1 pReset_N = 1'b0;
        #1;
        n_checks++;
        if ({a_ready, a_head, a_sh, a_isol, a_busy, a_done, a_err} !== 7'b0) begin
            n_errors++; $display("FAIL reset_mid_async got %b expected 0000000",
                                 {a_ready, a_head, a_sh, a_isol, a_busy, a_done, a_err});
        end
        @(negedge prog_clk);
        pReset_N = 1'b1;
        fill_random();
        program_run(0, 1'b0, 1'b0);
        n_checks++;
        if (r_timeout || cur_chain() !== exp_chain() || {a_done, a_err, a_isol} !== 3'b101) begin
            n_errors++; $display("FAIL reset_mid_reprogram chain %h done %b err %b isol %b expected %h 1 0 1",
                                 cur_chain(), a_done, a_err, a_isol, exp_chain());
        end
    endtask

    task automatic test_start_ignored_restart();
        // DUT8 sits in DONE with crc_err=1 from the fault run
        sel = 1'b0; cur_len = 8;
        fill_random();
        program_run(0, 1'b0, 1'b1);
        n_checks++;
        if ({r_busy_after, r_done_after, r_isol_after} !== 3'b100) begin
            n_errors++; $display("FAIL restart_from_done busy %b done %b isol %b expected 1 0 0",
                                 r_busy_after, r_done_after, r_isol_after);
        end
        n_checks++;
        if (r_timeout || sh_cnt != 16 || r_sent[7:0] !== exp_bits()) begin
            n_errors++; $display("FAIL start_ignored_stream cycles %0d sent %b expected 16 %b", sh_cnt, r_sent[7:0], exp_bits());
        end
        n_checks++;
        if (cur_chain() !== exp_chain() || {a_done, a_err, a_isol} !== 3'b101) begin
            n_errors++; $display("FAIL start_ignored_result chain %h done %b err %b isol %b expected %h 1 0 1",
                                 cur_chain(), a_done, a_err, a_isol, exp_chain());
        end
    endtask

    task automatic test_random();
        int stall;
        for (int it = 0; it < 6; it++) begin
            sel = it[0]; cur_len = sel ? 10 : 8;
            stall = $urandom_range(0, 2);
            fill_random();
            program_run(stall, 1'b0, 1'b0);
            n_checks++;
            if (r_timeout || (r_sent & bit_mask()) !== exp_bits() || (r_rcvd & bit_mask()) !== exp_bits()) begin
                n_errors++; $display("FAIL random%0d_stream sent %b rcvd %b expected %b", it, r_sent, r_rcvd, exp_bits());
            end
            n_checks++;
            if (cur_chain() !== exp_chain() || {a_done, a_err, a_isol} !== 3'b101 || r_hs != n_words()) begin
                n_errors++; $display("FAIL random%0d_result chain %h status %b hs %0d expected %h 101 %0d",
                                     it, cur_chain(), {a_done, a_err, a_isol}, r_hs, exp_chain(), n_words());
            end
            n_checks++;
            if (r_edges != 2 * cur_len + n_words() + 1 + stall * (n_words() - 1) || r_viol != 0) begin
                n_errors++; $display("FAIL random%0d_latency got %0d expected %0d", it, r_edges,
                                     2 * cur_len + n_words() + 1 + stall * (n_words() - 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic8();
        test_partial10(0);
        test_partial10(5);
        test_fault();
        test_start_ignored_restart();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ccff_bitstream_loader
`default_nettype wire
